// File: rtl/johnson_disp_pkg.sv
// Shared widths, seven-segment patterns and the Johnson-code decode helpers
// used by the step display.
package johnson_disp_pkg;

  localparam int JC_WIDTH   = 16;
  localparam int STEP_WIDTH = 5;
  localparam int SEG_WIDTH  = 7;
  localparam int NUM_DIGITS = 2;

  typedef logic [SEG_WIDTH-1:0] seg_t;

  // Digit codes beyond 0..9 that the encoder understands.
  localparam logic [3:0] DIGIT_E     = 4'hE;
  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  // Active-high patterns, bit0 = segment a ... bit6 = segment g.
  localparam seg_t SEG_DIGITS [0:9] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  localparam seg_t SEG_E     = 7'h79;
  localparam seg_t SEG_BLANK = 7'h00;

  typedef enum logic {
    DIGIT_UNITS = 1'b0,
    DIGIT_TENS  = 1'b1
  } digit_sel_e;

  typedef struct packed {
    logic                  legal;
    logic [STEP_WIDTH-1:0] step;
  } jc_decode_t;

  // Filling codes are a low-anchored run of ones; draining codes are a
  // high-anchored run of ones with bit0 clear. Each check reduces to
  // "x & (x+1) == 0" on the run (or on its complement).
  function automatic jc_decode_t jc_decode(input logic [JC_WIDTH-1:0] code);
    jc_decode_t         res;
    logic [5:0]         ones;
    logic [5:0]         drain_step;
    logic [JC_WIDTH:0]  run;
    ones = '0;
    for (int i = 0; i < JC_WIDTH; i++) begin
      ones = ones + {5'd0, code[i]};
    end
    drain_step = 6'd32 - ones;
    if (code[0] || (code == '0)) begin
      run       = {1'b0, code};
      res.legal = ((run & (run + 17'd1)) == '0);
      res.step  = ones[STEP_WIDTH-1:0];
    end else begin
      run       = {1'b0, ~code};
      res.legal = ((run & (run + 17'd1)) == '0);
      res.step  = drain_step[STEP_WIDTH-1:0];
    end
    return res;
  endfunction

  // Returns {tens, units} for a step value 0..31.
  function automatic logic [7:0] split_bcd(input logic [STEP_WIDTH-1:0] value);
    logic [3:0] tens;
    logic [3:0] units;
    if (value >= 5'd30) begin
      tens  = 4'd3;
      units = 4'(value - 5'd30);
    end else if (value >= 5'd20) begin
      tens  = 4'd2;
      units = 4'(value - 5'd20);
    end else if (value >= 5'd10) begin
      tens  = 4'd1;
      units = 4'(value - 5'd10);
    end else begin
      tens  = 4'd0;
      units = 4'(value);
    end
    return {tens, units};
  endfunction

endpackage

// File: rtl/seg7_encode.sv
// Combinational digit-code to seven-segment encoder, active-high output.
// Codes 0..9 are numerals, DIGIT_E shows 'E', anything else is blank.
module seg7_encode
  import johnson_disp_pkg::*;
(
  input  logic [3:0]           digit,
  output logic [SEG_WIDTH-1:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (digit <= 4'd9) begin
      seg = SEG_DIGITS[digit];
    end else if (digit == DIGIT_E) begin
      seg = SEG_E;
    end
  end

endmodule

// File: rtl/johnson_step_display.sv
// Decodes an asynchronous 16-bit Johnson counter into a 0..31 step index,
// flags illegal codes and sequence skips, and drives a two-digit muxed display.
module johnson_step_display
  import johnson_disp_pkg::*;
#(
  parameter int CLK_HZ         = 50000000,
  parameter int SCAN_HZ        = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [JC_WIDTH-1:0]   jc_in,
  input  logic                  clr_err,
  output logic [STEP_WIDTH-1:0] step,
  output logic                  step_valid,
  output logic                  change_pulse,
  output logic                  illegal,
  output logic                  seq_err,
  output logic [SEG_WIDTH-1:0]  seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] digit_en
);

  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int CNT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);

  // Synchronizer, history register and the acceptance-fill counter.
  logic [JC_WIDTH-1:0]   s1_reg, s2_reg, s3_reg;
  logic [1:0]            fill_reg, fill_next;

  // Decode state.
  logic [STEP_WIDTH-1:0] step_reg, step_next;
  logic                  step_valid_reg, step_valid_next;
  logic                  change_reg, change_next;
  logic                  illegal_reg, illegal_next;
  logic                  seq_err_reg, seq_err_next;
  logic                  have_prev_reg, have_prev_next;

  // Display state.
  logic [CNT_W-1:0]      scan_cnt_reg, scan_cnt_next;
  digit_sel_e            digit_sel_reg, digit_sel_next;
  logic [SEG_WIDTH-1:0]  seg_reg;
  logic                  dp_reg;
  logic [NUM_DIGITS-1:0] digit_en_reg;

  jc_decode_t            dec;
  logic                  accept;
  logic                  illegal_set;
  logic                  seq_set;
  logic [STEP_WIDTH-1:0] step_inc;

  // fill_reg guarantees s3 holds a post-reset sample before anything is
  // accepted, so a fresh code always takes four edges to reach the outputs.
  always_comb begin
    fill_next = (fill_reg == 2'd3) ? fill_reg : fill_reg + 2'd1;
    dec       = jc_decode(s2_reg);
    accept    = (fill_reg == 2'd3) && (s2_reg == s3_reg);
    step_inc  = step_reg + 5'd1;

    step_next       = step_reg;
    step_valid_next = step_valid_reg;
    change_next     = 1'b0;
    have_prev_next  = have_prev_reg;
    illegal_set     = 1'b0;
    seq_set         = 1'b0;

    if (accept) begin
      if (dec.legal) begin
        step_valid_next = 1'b1;
        step_next       = dec.step;
        have_prev_next  = 1'b1;
        if (dec.step != step_reg) begin
          change_next = 1'b1;
          seq_set     = have_prev_reg && (dec.step != step_inc);
        end
      end else begin
        step_valid_next = 1'b0;
        illegal_set     = 1'b1;
      end
    end

    // A new error in the same cycle as clr_err takes priority.
    illegal_next = illegal_set ? 1'b1 : (clr_err ? 1'b0 : illegal_reg);
    seq_err_next = seq_set     ? 1'b1 : (clr_err ? 1'b0 : seq_err_reg);
  end

  logic [7:0]            bcd;
  logic [3:0]            digit_code;
  logic [SEG_WIDTH-1:0]  seg_raw;
  logic [SEG_WIDTH-1:0]  seg_drive;
  logic                  dp_lit;
  logic                  dp_drive;
  logic [NUM_DIGITS-1:0] en_onehot;
  logic [NUM_DIGITS-1:0] en_drive;

  always_comb begin
    scan_cnt_next  = scan_cnt_reg + CNT_W'(1);
    digit_sel_next = digit_sel_reg;
    if (scan_cnt_reg == SCAN_LAST) begin
      scan_cnt_next  = '0;
      digit_sel_next = (digit_sel_reg == DIGIT_UNITS) ? DIGIT_TENS : DIGIT_UNITS;
    end

    bcd = split_bcd(step_reg);
    if (!step_valid_reg) begin
      digit_code = DIGIT_E;
    end else if (digit_sel_reg == DIGIT_TENS) begin
      digit_code = bcd[7:4];
    end else begin
      digit_code = bcd[3:0];
    end

    dp_lit    = seq_err_reg && (digit_sel_reg == DIGIT_UNITS);
    en_onehot = (digit_sel_reg == DIGIT_TENS) ? 2'b10 : 2'b01;
  end

  seg7_encode u_seg7 (
    .digit (digit_code),
    .seg   (seg_raw)
  );

  // Output polarity is applied per line just before the output registers.
  genvar gi;
  generate
    for (gi = 0; gi < SEG_WIDTH; gi++) begin : g_seg_pol
      assign seg_drive[gi] = seg_raw[gi] ^ SEG_ACTIVE_LOW;
    end
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_en_pol
      assign en_drive[gi] = en_onehot[gi] ^ SEG_ACTIVE_LOW;
    end
  endgenerate

  assign dp_drive = dp_lit ^ SEG_ACTIVE_LOW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_reg         <= '0;
      s2_reg         <= '0;
      s3_reg         <= '0;
      fill_reg       <= '0;
      step_reg       <= '0;
      step_valid_reg <= 1'b0;
      change_reg     <= 1'b0;
      illegal_reg    <= 1'b0;
      seq_err_reg    <= 1'b0;
      have_prev_reg  <= 1'b0;
      scan_cnt_reg   <= '0;
      digit_sel_reg  <= DIGIT_UNITS;
      seg_reg        <= {SEG_WIDTH{SEG_ACTIVE_LOW}};
      dp_reg         <= SEG_ACTIVE_LOW;
      digit_en_reg   <= {NUM_DIGITS{SEG_ACTIVE_LOW}};
    end else begin
      s1_reg         <= jc_in;
      s2_reg         <= s1_reg;
      s3_reg         <= s2_reg;
      fill_reg       <= fill_next;
      step_reg       <= step_next;
      step_valid_reg <= step_valid_next;
      change_reg     <= change_next;
      illegal_reg    <= illegal_next;
      seq_err_reg    <= seq_err_next;
      have_prev_reg  <= have_prev_next;
      scan_cnt_reg   <= scan_cnt_next;
      digit_sel_reg  <= digit_sel_next;
      seg_reg        <= seg_drive;
      dp_reg         <= dp_drive;
      digit_en_reg   <= en_drive;
    end
  end

  assign step         = step_reg;
  assign step_valid   = step_valid_reg;
  assign change_pulse = change_reg;
  assign illegal      = illegal_reg;
  assign seq_err      = seq_err_reg;
  assign seg          = seg_reg;
  assign dp           = dp_reg;
  assign digit_en     = digit_en_reg;

endmodule

// File: tb/tb_johnson_step_display.sv
// Self-checking bench for johnson_step_display; expected values come from a
// table-driven step model and a numeric display model kept in the bench.
module tb_johnson_step_display;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] jc_in = 16'h0000;
  logic        clr_err = 1'b0;
  logic [4:0]  step;
  logic        step_valid, change_pulse, illegal, seq_err, dp;
  logic [6:0]  seg;
  logic [1:0]  digit_en;

  johnson_step_display #(
    .CLK_HZ         (1000),
    .SCAN_HZ        (250),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .jc_in        (jc_in),
    .clr_err      (clr_err),
    .step         (step),
    .step_valid   (step_valid),
    .change_pulse (change_pulse),
    .illegal      (illegal),
    .seq_err      (seq_err),
    .seg          (seg),
    .dp           (dp),
    .digit_en     (digit_en)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int pulse_cnt = 0;

  // Model: the 32 legal codes listed by step, plus the sticky flags.
  int legal_code [32];
  int m_step;
  bit m_valid, m_illegal, m_seq, m_have_prev;

  function automatic int model_decode(input logic [15:0] code);
    for (int k = 0; k < 32; k++) begin
      if (legal_code[k] == {16'd0, code}) return k;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_step = 0; m_valid = 0; m_illegal = 0; m_seq = 0; m_have_prev = 0;
  endtask

  task automatic model_apply(input logic [15:0] code, output int exp_pulse);
    int s;
    s = model_decode(code);
    exp_pulse = 0;
    if (s >= 0) begin
      if (s != m_step) begin
        exp_pulse = 1;
        if (m_have_prev && s != (m_step + 1) % 32) m_seq = 1;
      end
      m_step = s; m_valid = 1; m_have_prev = 1;
    end else begin
      m_valid = 0; m_illegal = 1;
    end
  endtask

  task automatic model_clear(input logic [15:0] code);
    m_seq = 0;
    m_illegal = (model_decode(code) < 0);
  endtask

  function automatic logic [6:0] pattern(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;  14: return 7'h79;
      default: return 7'h00;
    endcase
  endfunction

  // Active-low segment value the model expects for one digit position.
  function automatic logic [6:0] exp_seg(input bit tens_digit);
    int d;
    if (!m_valid) d = 14;
    else d = tens_digit ? m_step / 10 : m_step % 10;
    return ~pattern(d);
  endfunction

  task automatic hold(input logic [15:0] code, input int n);
    jc_in = code;
    repeat (n) begin
      @(posedge clk); @(negedge clk);
      if (change_pulse === 1'b1) pulse_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    checks++; if (digit_en !== 2'b11) begin fails++; $display("FAIL reset_digit_en got %b want 11", digit_en); end
    checks++; if (seg !== 7'h7F) begin fails++; $display("FAIL reset_seg got %h want 7f", seg); end
    checks++; if (dp !== 1'b1) begin fails++; $display("FAIL reset_dp got %b want 1", dp); end
    checks++; if ({step, step_valid, change_pulse, illegal, seq_err} !== 9'd0) begin
      fails++; $display("FAIL reset_flags got step=%0d v=%b p=%b i=%b s=%b want all 0",
                        step, step_valid, change_pulse, illegal, seq_err);
    end
  endtask

  task automatic test_display(input string tag);
    int seen_u, seen_t;
    seen_u = 0; seen_t = 0;
    repeat (8) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (digit_en === 2'b10) begin
        seen_u++;
        if (seg !== exp_seg(1'b0) || dp !== !m_seq) begin
          fails++; $display("FAIL display_%s units seg=%h dp=%b want seg=%h dp=%b",
                            tag, seg, dp, exp_seg(1'b0), !m_seq);
        end
      end else if (digit_en === 2'b01) begin
        seen_t++;
        if (seg !== exp_seg(1'b1) || dp !== 1'b1) begin
          fails++; $display("FAIL display_%s tens seg=%h dp=%b want seg=%h dp=1",
                            tag, seg, dp, exp_seg(1'b1));
        end
      end else begin
        fails++; $display("FAIL display_%s digit_en got %b want one digit enabled", tag, digit_en);
      end
    end
    checks++;
    if (seen_u == 0 || seen_t == 0) begin
      fails++; $display("FAIL display_%s scan saw units=%0d tens=%0d want both nonzero", tag, seen_u, seen_t);
    end
  endtask

  task automatic test_first_step();
    int p;
    jc_in = 16'h0000;
    rst = 1'b0;
    pulse_cnt = 0;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk); @(negedge clk);
      if (change_pulse === 1'b1) pulse_cnt++;
      checks++;
      if (step_valid !== (e == 4)) begin
        fails++; $display("FAIL first_step_latency edge %0d valid got %b want %b", e, step_valid, e == 4);
      end
    end
    model_apply(16'h0000, p);
    checks++; if (step !== 5'd0 || pulse_cnt != p) begin
      fails++; $display("FAIL first_step got step=%0d pulses=%0d want 0 and %0d", step, pulse_cnt, p);
    end
    test_display("00");
  endtask

  task automatic test_walk();
    int p;
    pulse_cnt = 0;
    for (int k = 1; k <= 32; k++) begin
      hold(16'(legal_code[k % 32]), 8);
      model_apply(16'(legal_code[k % 32]), p);
      checks++;
      if (step !== 5'(k % 32) || step_valid !== 1'b1) begin
        fails++; $display("FAIL walk_step code=%h got step=%0d v=%b want %0d v=1",
                          jc_in, step, step_valid, k % 32);
      end
    end
    checks++; if (pulse_cnt != 32) begin fails++; $display("FAIL walk_pulses got %0d want 32", pulse_cnt); end
    checks++; if (seq_err !== 1'b0) begin fails++; $display("FAIL walk_seq_err got %b want 0", seq_err); end
  endtask

  task automatic test_illegal();
    int held, p;
    logic [15:0] code;
    held = m_step;
    pulse_cnt = 0;
    hold(16'h00F0, 6);
    model_apply(16'h00F0, p);
    checks++; if (illegal !== 1'b1) begin fails++; $display("FAIL illegal_flag got %b want 1", illegal); end
    checks++; if (step_valid !== 1'b0) begin fails++; $display("FAIL illegal_valid got %b want 0", step_valid); end
    checks++; if (step !== 5'(held) || pulse_cnt != 0) begin
      fails++; $display("FAIL illegal_hold got step=%0d pulses=%0d want %0d and 0", step, pulse_cnt, held);
    end
    test_display("illegal");
    clr_err = 1'b1; hold(16'h00F0, 1); clr_err = 1'b0;
    hold(16'h00F0, 3);
    checks++; if (illegal !== 1'b1) begin fails++; $display("FAIL illegal_clr_persist got %b want 1", illegal); end
    code = 16'(legal_code[(m_step + 1) % 32]);
    hold(code, 7); clr_err = 1'b1; hold(code, 1); clr_err = 1'b0;
    model_apply(code, p); model_clear(code);
    checks++; if (illegal !== 1'b0 || step_valid !== 1'b1 || step !== 5'(m_step)) begin
      fails++; $display("FAIL illegal_clear got i=%b v=%b step=%0d want 0 1 %0d", illegal, step_valid, step, m_step);
    end
  endtask

  task automatic test_seq_err();
    int p;
    hold(16'h0003, 8); model_apply(16'h0003, p);
    hold(16'h000F, 8); model_apply(16'h000F, p);
    checks++; if (step !== 5'd4 || seq_err !== 1'b1) begin
      fails++; $display("FAIL seq_skip got step=%0d seq_err=%b want 4 and 1", step, seq_err);
    end
    test_display("seq");
    hold(16'h000F, 5); clr_err = 1'b1; hold(16'h000F, 1); clr_err = 1'b0;
    model_clear(16'h000F);
    checks++; if (seq_err !== 1'b0) begin fails++; $display("FAIL seq_clear got %b want 0", seq_err); end
  endtask

  task automatic test_glitch();
    int p;
    hold(16'h0003, 8); model_apply(16'h0003, p);
    pulse_cnt = 0;
    hold(16'h0007, 1);
    hold(16'h0003, 8);
    checks++; if (pulse_cnt != 0) begin fails++; $display("FAIL glitch_pulse got %0d want 0", pulse_cnt); end
    checks++; if (step !== 5'(m_step) || step_valid !== 1'b1) begin
      fails++; $display("FAIL glitch_step got %0d v=%b want %0d v=1", step, step_valid, m_step);
    end
  endtask

  task automatic test_random();
    logic [15:0] code;
    int n, p;
    bit use_clr;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) != 0) code = 16'(legal_code[$urandom_range(0, 31)]);
      else code = 16'($urandom);
      n = $urandom_range(5, 8);
      use_clr = ($urandom_range(0, 4) == 0);
      pulse_cnt = 0;
      if (use_clr) begin
        hold(code, n - 1); clr_err = 1'b1; hold(code, 1); clr_err = 1'b0;
        model_apply(code, p); model_clear(code);
      end else begin
        hold(code, n);
        model_apply(code, p);
      end
      $display("txn %0d code=%h hold=%0d clr=%0d step=%0d valid=%b illegal=%b seq_err=%b pulses=%0d",
               t, code, n, use_clr, step, step_valid, illegal, seq_err, pulse_cnt);
      checks++;
      if ({step, step_valid, illegal, seq_err} !== {5'(m_step), m_valid, m_illegal, m_seq}) begin
        fails++; $display("FAIL random_state txn %0d got step=%0d v=%b i=%b s=%b want step=%0d v=%b i=%b s=%b",
                          t, step, step_valid, illegal, seq_err, m_step, m_valid, m_illegal, m_seq);
      end
      checks++;
      if (pulse_cnt != p) begin
        fails++; $display("FAIL random_pulse txn %0d got %0d want %0d", t, pulse_cnt, p);
      end
    end
  endtask

  task automatic test_scan();
    int p;
    logic [1:0] want_en;
    @(negedge clk);
    rst = 1'b1;
    jc_in = 16'(legal_code[5]);
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pulse_cnt = 0;
    for (int e = 1; e <= 12; e++) begin
      @(posedge clk); @(negedge clk);
      if (change_pulse === 1'b1) pulse_cnt++;
      want_en = (((e - 1) / 4) % 2 == 0) ? 2'b10 : 2'b01;
      checks++;
      if (digit_en !== want_en) begin
        fails++; $display("FAIL scan_alternate edge %0d got %b want %b", e, digit_en, want_en);
      end
    end
    model_apply(16'(legal_code[5]), p);
    checks++; if (step !== 5'd5 || step_valid !== 1'b1 || pulse_cnt != p || seq_err !== 1'b0) begin
      fails++; $display("FAIL scan_first_step got step=%0d v=%b pulses=%0d s=%b want 5 1 %0d 0",
                        step, step_valid, pulse_cnt, seq_err, p);
    end
    // Reset lands mid-scan and while a new code is still in the synchronizer.
    jc_in = 16'(legal_code[9]);
    @(posedge clk); @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (digit_en !== 2'b11 || seg !== 7'h7F || dp !== 1'b1) begin
      fails++; $display("FAIL midreset_display got en=%b seg=%h dp=%b want 11 7f 1", digit_en, seg, dp);
    end
    checks++; if (step !== 5'd0 || step_valid !== 1'b0 || change_pulse !== 1'b0) begin
      fails++; $display("FAIL midreset_state got step=%0d v=%b p=%b want 0 0 0", step, step_valid, change_pulse);
    end
    model_reset();
    @(negedge clk); jc_in = 16'h0000;
    @(negedge clk); rst = 1'b0;
    pulse_cnt = 0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); @(negedge clk);
      if (change_pulse === 1'b1) pulse_cnt++;
      if (e == 1) begin
        checks++;
        if (digit_en !== 2'b10) begin fails++; $display("FAIL midreset_units_first got %b want 10", digit_en); end
      end
    end
    model_apply(16'h0000, p);
    checks++; if (pulse_cnt != p || step !== 5'd0 || step_valid !== 1'b1) begin
      fails++; $display("FAIL midreset_release got pulses=%0d step=%0d v=%b want %0d 0 1",
                        pulse_cnt, step, step_valid, p);
    end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) begin
      legal_code[k] = (k <= 16) ? ((1 << k) - 1) : ((32'hFFFF << (k - 16)) & 32'hFFFF);
    end
    test_reset();
    test_first_step();
    test_walk();
    test_illegal();
    test_seq_err();
    test_glitch();
    test_random();
    test_scan();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
